csa5_chunk_sequencer: RTL and testbench

//  Multi-cycle wide adder that feeds one shared csa_5bit instance. Operands are split into 5-bit chunks, LSB chunk first.
//  csa_5bit has no carry-in, so an incoming carry is added in a second adder pass (INC) on the same chunk.

---
 rtl/csa5_chunk_sequencer.sv | 154 +++++++++++++++
 tb/tb_csa5_chunk_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/csa5_chunk_sequencer.sv
// Wide adder that sequences 5-bit chunks, LSB first, through one shared csa_5bit.
// A carry into a chunk costs a second pass (INC) because csa_5bit has no carry-in.

module csa_5bit (
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [4:0] sum,
   output logic       cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// state | meaning
// IDLE  | o_ready high, adder inputs parked at 0
// ADD   | add chunk k of A and B
// INC   | add 1 to the ADD result of chunk k (incoming carry)
// DONE  | o_valid high, result held until i_ready
module csa5_chunk_sequencer #(
   parameter int OP_WIDTH = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [OP_WIDTH-1:0] i_add_term1,
   input  logic [OP_WIDTH-1:0] i_add_term2,
   input  logic                i_cin,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [OP_WIDTH-1:0] o_sum,
   output logic                o_cout,
   output logic [7:0]          o_cycles
);
   localparam int NUM_CHUNKS = OP_WIDTH / 5;
   localparam logic [3:0] K_LAST = 4'(NUM_CHUNKS - 1);

   if ((OP_WIDTH % 5) != 0 || OP_WIDTH < 5 || OP_WIDTH > 40) begin : g_bad_width
      $error("csa5_chunk_sequencer: OP_WIDTH must be a multiple of 5 in 5..40");
   end

   typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

   state_t              state;
   logic [OP_WIDTH-1:0] a_q;
   logic [OP_WIDTH-1:0] b_q;
   logic [OP_WIDTH-1:0] res;
   logic [OP_WIDTH-1:0] res_next;
   logic [3:0]          k;
   logic [7:0]          cnt;
   logic                c;
   logic                tc;
   logic [4:0]          tmp;
   logic [4:0]          add_a;
   logic [4:0]          add_b;
   logic [4:0]          add_sum;
   logic                add_cout;
   logic                wb_c;

   assign o_ready = (state == IDLE) & ~rst;

   // Operands shift right on every advance, so the active chunk is always bits [4:0].
   always_comb begin
      add_a = 5'd0;
      add_b = 5'd0;
      case (state)
         ADD: begin
            add_a = a_q[4:0];
            add_b = b_q[4:0];
         end
         INC: begin
            add_a = tmp;
            add_b = 5'd1;
         end
         default: ;
      endcase
   end

   csa_5bit u_csa (
      .a    (add_a),
      .b    (add_b),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Result fills from the top; after NUM_CHUNKS writes chunk 0 sits at bits [4:0].
   if (OP_WIDTH == 5) begin : g_res_one
      assign res_next = add_sum;
   end else begin : g_res_many
      assign res_next = {add_sum, res[OP_WIDTH-1:5]};
   end

   assign wb_c = (state == INC) ? (tc | add_cout) : add_cout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res      <= '0;
         k        <= '0;
         cnt      <= '0;
         c        <= 1'b0;
         tc       <= 1'b0;
         tmp      <= '0;
         o_valid  <= 1'b0;
         o_sum    <= '0;
         o_cout   <= 1'b0;
         o_cycles <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_q   <= i_add_term1;
                  b_q   <= i_add_term2;
                  c     <= i_cin;
                  k     <= '0;
                  cnt   <= '0;
                  state <= ADD;
               end
            end
            ADD, INC: begin
               cnt <= cnt + 8'd1;
               if (state == ADD && c) begin
                  tmp   <= add_sum;
                  tc    <= add_cout;
                  state <= INC;
               end else begin
                  res <= res_next;
                  c   <= wb_c;
                  if (k == K_LAST) begin
                     state    <= DONE;
                     o_valid  <= 1'b1;
                     o_sum    <= res_next;
                     o_cout   <= wb_c;
                     o_cycles <= cnt + 8'd1;
                  end else begin
                     k     <= k + 4'd1;
                     a_q   <= a_q >> 5;
                     b_q   <= b_q >> 5;
                     state <= ADD;
                  end
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csa5_chunk_sequencer.sv
// Directed and randomized checks of csa5_chunk_sequencer at widths 20, 5 and 40.
`timescale 1ns/1ps
module tb_csa5_chunk_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid [3];
   logic [39:0] in_a     [3];
   logic [39:0] in_b     [3];
   logic        in_cin   [3];
   logic        in_ready [3];
   logic        out_ready[3];
   logic        out_valid[3];
   logic [39:0] out_sum  [3];
   logic        out_cout [3];
   logic [7:0]  out_cyc  [3];

   logic [19:0] s20;
   logic [4:0]  s5;
   logic [39:0] s40;

   int n_checks = 0;
   int n_errors = 0;

   csa5_chunk_sequencer #(.OP_WIDTH(20)) u_d20 (
      .clk(clk), .rst(rst), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
      .i_add_term1(in_a[0][19:0]), .i_add_term2(in_b[0][19:0]), .i_cin(in_cin[0]),
      .o_valid(out_valid[0]), .i_ready(in_ready[0]), .o_sum(s20),
      .o_cout(out_cout[0]), .o_cycles(out_cyc[0]));

   csa5_chunk_sequencer #(.OP_WIDTH(5)) u_d5 (
      .clk(clk), .rst(rst), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
      .i_add_term1(in_a[1][4:0]), .i_add_term2(in_b[1][4:0]), .i_cin(in_cin[1]),
      .o_valid(out_valid[1]), .i_ready(in_ready[1]), .o_sum(s5),
      .o_cout(out_cout[1]), .o_cycles(out_cyc[1]));

   csa5_chunk_sequencer #(.OP_WIDTH(40)) u_d40 (
      .clk(clk), .rst(rst), .i_valid(in_valid[2]), .o_ready(out_ready[2]),
      .i_add_term1(in_a[2]), .i_add_term2(in_b[2]), .i_cin(in_cin[2]),
      .o_valid(out_valid[2]), .i_ready(in_ready[2]), .o_sum(s40),
      .o_cout(out_cout[2]), .o_cycles(out_cyc[2]));

   assign out_sum[0] = {20'd0, s20};
   assign out_sum[1] = {35'd0, s5};
   assign out_sum[2] = s40;

   function automatic int width_of(input int sel);
      case (sel)
         0: return 20;
         1: return 5;
         default: return 40;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One full transaction with golden sum and an independent INC-count prediction.
   task automatic do_op(input int sel, input logic [39:0] a, input logic [39:0] b,
                        input logic cin, input int rdy_wait, input string tag);
      int          w;
      int          n_chunks;
      int          inc;
      int          lat;
      logic [39:0] mask;
      logic [40:0] full;
      logic [39:0] exp_sum;
      logic        exp_cout;
      logic [39:0] carries;
      logic [39:0] hold;
      w        = width_of(sel);
      n_chunks = w / 5;
      mask     = (40'd1 << w) - 40'd1;
      full     = {1'b0, a & mask} + {1'b0, b & mask} + {40'd0, cin};
      exp_sum  = full[39:0] & mask;
      exp_cout = full[w];
      carries  = (a ^ b ^ exp_sum) & mask;
      inc = 0;
      for (int j = 0; j < n_chunks; j++) if (carries[5*j]) inc++;

      @(negedge clk);
      in_a[sel] = a; in_b[sel] = b; in_cin[sel] = cin; in_valid[sel] = 1'b1;
      chk({tag, "_ready_idle"}, {39'd0, out_ready[sel]}, 40'd1);
      @(posedge clk); #1;
      // Keep i_valid up and scramble operands while busy: both must be ignored.
      in_a[sel] = {$urandom, $urandom}; in_b[sel] = {$urandom, $urandom};
      in_cin[sel] = $urandom_range(0, 1);
      chk({tag, "_ready_busy"}, {39'd0, out_ready[sel]}, 40'd0);
      lat = 1;
      while (!out_valid[sel] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      in_valid[sel] = 1'b0;
      chk({tag, "_latency"}, 40'(lat), 40'(1 + n_chunks + inc));
      chk({tag, "_sum"}, out_sum[sel], exp_sum);
      chk({tag, "_cout"}, {39'd0, out_cout[sel]}, {39'd0, exp_cout});
      chk({tag, "_cycles"}, {32'd0, out_cyc[sel]}, 40'(n_chunks + inc));
      hold = out_sum[sel];
      repeat (rdy_wait) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, {39'd0, out_valid[sel]}, 40'd1);
         chk({tag, "_hold_sum"}, out_sum[sel], hold);
         chk({tag, "_hold_ready"}, {39'd0, out_ready[sel]}, 40'd0);
      end
      in_ready[sel] = 1'b1;
      @(posedge clk); #1;
      in_ready[sel] = 1'b0;
      chk({tag, "_drop_valid"}, {39'd0, out_valid[sel]}, 40'd0);
      chk({tag, "_ready_after"}, {39'd0, out_ready[sel]}, 40'd1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; in_cin[i] = 1'b0; in_ready[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", {39'd0, out_ready[i]}, 40'd0);
         chk("rst_valid", {39'd0, out_valid[i]}, 40'd0);
         chk("rst_sum", out_sum[i], 40'd0);
         chk("rst_cout", {39'd0, out_cout[i]}, 40'd0);
         chk("rst_cycles", {32'd0, out_cyc[i]}, 40'd0);
      end
      rst = 1'b0;
      #1;
      chk("rst_release_ready", {39'd0, out_ready[0]}, 40'd1);

      // i_ready while idle must not create a result.
      in_ready[0] = 1'b1;
      @(posedge clk); #1;
      in_ready[0] = 1'b0;
      chk("idle_iready_valid", {39'd0, out_valid[0]}, 40'd0);

      do_op(0, 40'h00001, 40'h00002, 1'b0, 0, "T1");
      do_op(0, 40'hFFFFF, 40'h00001, 1'b0, 0, "T2");
      do_op(0, 40'hFFFFF, 40'h00000, 1'b1, 0, "T3");
      do_op(0, 40'h12345, 40'h6789A, 1'b1, 5, "T4");

      // T5: reset in the middle of an all-INC operation.
      @(negedge clk);
      in_a[0] = 40'hFFFFF; in_b[0] = 40'h0; in_cin[0] = 1'b1; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("T5_rst_valid", {39'd0, out_valid[0]}, 40'd0);
      chk("T5_rst_sum", out_sum[0], 40'd0);
      chk("T5_rst_ready", {39'd0, out_ready[0]}, 40'd0);
      rst = 1'b0;
      #1;
      chk("T5_idle_ready", {39'd0, out_ready[0]}, 40'd1);
      repeat (10) begin
         @(posedge clk); #1;
         chk("T5_no_stale_valid", {39'd0, out_valid[0]}, 40'd0);
      end
      do_op(0, 40'h5, 40'h5, 1'b0, 1, "T5_new");

      do_op(1, 40'h1F, 40'h01, 1'b0, 0, "W5_wrap");
      do_op(1, 40'h1F, 40'h00, 1'b1, 0, "W5_inc");
      do_op(2, 40'hFF_FFFF_FFFF, 40'h0, 1'b1, 0, "W40_allinc");
      do_op(2, 40'h80_0000_0000, 40'h80_0000_0000, 1'b0, 0, "W40_top");

      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_op(0, {8'd0, $urandom}, {8'd0, $urandom}, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), "T6_w20");
      end
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_op(1, {8'd0, $urandom}, {8'd0, $urandom}, 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), "T6_w5");
         do_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), "T6_w40");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
